xc_malu_ctrl: RTL
=================

Name: xc_malu_ctrl

Overview:
Sequencer and state-register stage for the multi-precision ALU; sits directly upstream of the long-arithmetic datapath.
- Owns the acc/carry/count registers and drives the one-hot fsm_* step strobes.
- Captures the datapath's next-state values (n_acc, n_carry) and signals instruction completion to the pipeline.
- Handles madd, msub, macc and mmul.

Parameters:
- None.

Ports:
g_clk  in  1  clock
g_reset  in  1  asynchronous active-high reset
valid  in  1  instruction request; held with operands until ready
flush  in  1  synchronous abort of the current instruction
uop_madd  in  1  one-hot op select
uop_msub  in  1  one-hot op select
uop_macc  in  1  one-hot op select
uop_mmul  in  1  one-hot op select
n_acc  in  64  next accumulator from datapath
n_carry  in  1  next carry from datapath
fsm_init  out  1  first step of op
fsm_mdr  out  1  multiply iteration step
fsm_msub_1  out  1  msub second step
fsm_macc_1  out  1  macc second step
fsm_mmul_1  out  1  mmul add-rs3 step
fsm_mmul_2  out  1  mmul carry-propagate step
fsm_done  out  1  completion state
acc  out  64  accumulator register
carry  out  1  carry register
count  out  6  multiply iteration counter
ready  out  1  instruction complete, result valid this cycle
busy  out  1  state != INIT
illegal  out  1  unsupported op completed (see optional feature)

Behaviour:
- Reset (async, any state): state=INIT, acc=0, carry=0, count=0. All fsm_* except fsm_init are 0; ready=0, illegal=0.
- States, one-hot: INIT, MDR, MSUB_1, MACC_1, MMUL_1, MMUL_2, DONE. Each fsm_* output equals its state bit.
- fsm_init is 1 in INIT regardless of valid. The datapath qualifies it with its uop inputs.
- Register updates only when valid=1 and flush=0.
- INIT:
  - madd: acc<=n_acc, carry<=n_carry; ready=1 combinationally this cycle; stay in INIT. Latency 0.
  - msub: acc<=n_acc, carry<=n_carry; ->MSUB_1.
  - macc: acc<=n_acc, carry<=n_carry; ->MACC_1.
  - mmul: acc<=0, carry<=0, count<=0; ->MDR.
- MDR: acc<=n_acc, carry<=n_carry, count<=count+1. When count==31, ->MMUL_1 with count<=0. This gives exactly 32 MDR cycles.
- MSUB_1, MACC_1, MMUL_1, MMUL_2: acc<=n_acc, carry<=n_carry. Transitions:
  - MSUB_1->DONE
  - MACC_1->DONE
  - MMUL_1->MMUL_2
  - MMUL_2->DONE
- DONE: ready=1 for one cycle; acc holds; ->INIT.
- Latency from first valid cycle to ready:
  - madd: 0 (same cycle)
  - msub: 2
  - macc: 2
  - mmul: 35
- Back-to-back: a new op may start in the INIT cycle immediately after DONE.
- valid dropped in any non-INIT state: abort; next state INIT; carry=0, count=0; acc holds; no ready.
- flush=1: next state INIT; carry=0, count=0; acc holds; ready=0 that cycle. flush beats valid and ready, including in INIT and in DONE.
- Non-one-hot uop: priority madd>msub>macc>mmul. No uop set with valid=1 in INIT: no update, ready=0.
- busy=1 in every state except INIT.
- count is 6 bits; it never exceeds 31 and never wraps in normal operation.

Optional Feature:
Macro: XC_MALU_CTRL_MMUL_EN
- Defined: mmul sequenced as above; illegal tied 0.
- Undefined:
  - The MDR/MMUL_1/MMUL_2 path is removed.
  - valid&uop_mmul in INIT gives ready=1 and illegal=1 combinationally, with no acc/carry/count update and state staying INIT.
  - fsm_mdr, fsm_mmul_1 and fsm_mmul_2 are tied 0; count is tied 0.

Test Plan:
1. Reset mid-mmul: assert g_reset at MDR count=17 (async) -> same instant state INIT, acc=0, count=0, busy=0, fsm_init=1.
2. madd, n_acc=64'h0000_0000_FFFF_0001, n_carry=1 -> ready=1 same cycle. Next edge: acc=64'h0000_0000_FFFF_0001, carry=1, state stays INIT.
3. msub with valid held, n_acc driven 64'h5 then 64'h4 -> fsm_msub_1 on cycle 1, ready on cycle 2, acc=64'h4.
4. mmul with valid held -> fsm_mdr high for exactly 32 cycles, count 0..31. Then fsm_mmul_1, fsm_mmul_2, ready at cycle 35. acc equals last n_acc.
5. macc with flush=1 in MACC_1 -> next state INIT, no ready, carry=0. A following madd completes normally.
6. XC_MALU_CTRL_MMUL_EN undefined: valid&uop_mmul -> ready=1, illegal=1 same cycle, acc unchanged, fsm_mdr never asserted.

Source files
------------

// File: rtl/xc_malu_ctrl.sv
//----------------------------------------------------------------------------
// xc_malu_ctrl : multi-precision ALU sequencer owning acc/carry/count state.
// mmul sequencing is built only when XC_MALU_CTRL_MMUL_EN is defined.  Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module xc_malu_ctrl (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        valid,
  input  logic        flush,
  input  logic        uop_madd,
  input  logic        uop_msub,
  input  logic        uop_macc,
  input  logic        uop_mmul,
  input  logic [63:0] n_acc,
  input  logic        n_carry,
  output logic        fsm_init,
  output logic        fsm_mdr,
  output logic        fsm_msub_1,
  output logic        fsm_macc_1,
  output logic        fsm_mmul_1,
  output logic        fsm_mmul_2,
  output logic        fsm_done,
  output logic [63:0] acc,
  output logic        carry,
  output logic [5:0]  count,
  output logic        ready,
  output logic        busy,
  output logic        illegal
);

  typedef enum logic [6:0] {
    S_INIT   = 7'b000_0001,
    S_MDR    = 7'b000_0010,
    S_MSUB_1 = 7'b000_0100,
    S_MACC_1 = 7'b000_1000,
    S_MMUL_1 = 7'b001_0000,
    S_MMUL_2 = 7'b010_0000,
    S_DONE   = 7'b100_0000
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic        carry_q, carry_d;
  logic        op_madd, op_msub, op_macc, op_mmul;
  logic        abort;

  // Resolve non-one-hot selects with madd > msub > macc > mmul priority.
  assign op_madd = uop_madd;
  assign op_msub = ~uop_madd & uop_msub;
  assign op_macc = ~uop_madd & ~uop_msub & uop_macc;
  assign op_mmul = ~uop_madd & ~uop_msub & ~uop_macc & uop_mmul;

  assign abort = flush | ((state_q != S_INIT) & ~valid);

`ifdef XC_MALU_CTRL_MMUL_EN
  logic [5:0] count_q, count_d;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
`ifdef XC_MALU_CTRL_MMUL_EN
    count_d = count_q;
`endif
    ready   = 1'b0;
    illegal = 1'b0;
    if (abort) begin
      // acc deliberately holds so a partial result remains observable.
      state_d = S_INIT;
      carry_d = 1'b0;
`ifdef XC_MALU_CTRL_MMUL_EN
      count_d = 6'd0;
`endif
    end else begin
      case (state_q)
        S_INIT: begin
          if (valid) begin
            if (op_madd | op_msub | op_macc) begin
              acc_d   = n_acc;
              carry_d = n_carry;
            end
            if (op_madd) ready   = 1'b1;
            if (op_msub) state_d = S_MSUB_1;
            if (op_macc) state_d = S_MACC_1;
            if (op_mmul) begin
`ifdef XC_MALU_CTRL_MMUL_EN
              acc_d   = 64'd0;
              carry_d = 1'b0;
              count_d = 6'd0;
              state_d = S_MDR;
`else
              ready   = 1'b1;
              illegal = 1'b1;
`endif
            end
          end
        end
        S_MSUB_1, S_MACC_1: begin
          acc_d   = n_acc;
          carry_d = n_carry;
          state_d = S_DONE;
        end
`ifdef XC_MALU_CTRL_MMUL_EN
        S_MDR: begin
          acc_d   = n_acc;
          carry_d = n_carry;
          if (count_q == 6'd31) begin
            count_d = 6'd0;
            state_d = S_MMUL_1;
          end else begin
            count_d = count_q + 6'd1;
          end
        end
        S_MMUL_1: begin
          acc_d   = n_acc;
          carry_d = n_carry;
          state_d = S_MMUL_2;
        end
        S_MMUL_2: begin
          acc_d   = n_acc;
          carry_d = n_carry;
          state_d = S_DONE;
        end
`endif
        S_DONE: begin
          ready   = 1'b1;
          state_d = S_INIT;
        end
        default: begin
          state_d = S_INIT;
          carry_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q <= S_INIT;
      acc_q   <= 64'd0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

`ifdef XC_MALU_CTRL_MMUL_EN
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) count_q <= 6'd0;
    else         count_q <= count_d;
  end

  assign count      = count_q;
  assign fsm_mdr    = state_q[1];
  assign fsm_mmul_1 = state_q[4];
  assign fsm_mmul_2 = state_q[5];
`else
  logic unused_state;
  assign unused_state = ^{state_q[5:4], state_q[1]};
  assign count        = 6'd0;
  assign fsm_mdr      = 1'b0;
  assign fsm_mmul_1   = 1'b0;
  assign fsm_mmul_2   = 1'b0;
`endif

  assign fsm_init   = state_q[0];
  assign fsm_msub_1 = state_q[2];
  assign fsm_macc_1 = state_q[3];
  assign fsm_done   = state_q[6];
  assign acc        = acc_q;
  assign carry      = carry_q;
  assign busy       = (state_q != S_INIT);

endmodule

`default_nettype wire
